// File: rtl/loader_pkg.sv
// Shared types for the BIOS image loader.
// Loader control states used by bios_loader.
package loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FILL,
    FLUSH,
    DONE,
    ERR
  } state_t;

endpackage

// File: rtl/loader_fifo.sv
// First-word-fall-through FIFO for packed target words.
// Head is combinationally visible as soon as count is non-zero.
module loader_fifo #(
  parameter int W     = 16,
  parameter int DEPTH = 16,
  localparam int PW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  head,
  output logic          full,
  output logic          empty,
  output logic [PW:0]   count
);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wp;
  logic [PW-1:0] rp;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (PW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rp];

  always_ff @(posedge clk) begin
    if (do_push) mem[wp] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (do_push) wp <= wp + PW'(1);
      if (do_pop)  rp <= rp + PW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/bios_loader.sv
// Packs HPS ioctl download data into target words and streams
// them to a target memory, flagging completion or length error.
module bios_loader
  import loader_pkg::*;
#(
  parameter int IN_W      = 16,
  parameter int OUT_W     = 16,
  parameter int AW        = 13,
  parameter int IMG_WORDS = 8192,
  parameter int DEPTH     = 16,
  parameter int INDEX     = 0
) (
  input  logic             clk_sys,
  input  logic             reset_n,
  input  logic             ioctl_download,
  input  logic [15:0]      ioctl_index,
  input  logic             ioctl_wr,
  input  logic [IN_W-1:0]  ioctl_dout,
  output logic             ioctl_wait,
  input  logic             tgt_req,
  output logic             tgt_wr,
  output logic [AW-1:0]    tgt_addr,
  output logic [OUT_W-1:0] tgt_din,
  output logic             loaded,
  output logic             error
);

  localparam int RATIO = OUT_W / IN_W;
  localparam int CW    = $clog2(DEPTH) + 1;

  state_t           state;
  state_t           nxt;
  logic             dl_q;
  logic             match;
  logic             start;
  logic             fall;
  logic             accept;
  logic             last;
  logic             room;
  logic [1:0]       idx;
  logic [OUT_W-1:0] pack;
  logic [OUT_W-1:0] pack_nxt;
  logic [OUT_W-1:0] push_d;
  logic             push_v;
  logic             bad;
  logic [AW:0]      words;
  logic             fifo_push;
  logic             pop;
  logic             empty;
  logic             full;
  logic [OUT_W-1:0] head;
  logic [CW-1:0]    count;

  assign match  = (ioctl_index[5:0] == 6'(INDEX));
  assign start  = ioctl_download && !dl_q && match &&
                  (state != FILL) && (state != FLUSH);
  assign fall   = dl_q && !ioctl_download;
  assign accept = (state == FILL) && ioctl_download &&
                  ioctl_wr && match;
  assign last   = (idx == 2'(RATIO - 1));
  assign room   = (words < (AW+1)'(IMG_WORDS));

  assign fifo_push  = push_v && room;
  assign pop        = tgt_req && !empty;
  assign tgt_wr     = !empty;
  assign tgt_din    = empty ? '0 : head;
  assign ioctl_wait = (count >= CW'(DEPTH - 2));

  always_comb begin
    pack_nxt = pack;
    pack_nxt[idx*IN_W +: IN_W] = ioctl_dout;
  end

  loader_fifo #(
    .W     (OUT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk_sys),
    .rst_n (reset_n),
    .push  (fifo_push),
    .pop   (pop),
    .din   (push_d),
    .head  (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE, DONE, ERR: if (start) nxt = FILL;
      FILL:            if (fall) nxt = FLUSH;
      FLUSH: begin
        if (empty && !push_v)
          nxt = (bad || words != (AW+1)'(IMG_WORDS)) ? ERR : DONE;
      end
      default:         nxt = IDLE;
    endcase
  end

  always_comb begin
    loaded = (state == DONE);
    error  = (state == ERR);
  end

  // dl_q resets high so a download already in progress is not a new edge
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      dl_q     <= 1'b1;
      pack     <= '0;
      idx      <= '0;
      push_v   <= 1'b0;
      push_d   <= '0;
      words    <= '0;
      bad      <= 1'b0;
      tgt_addr <= '0;
    end else begin
      dl_q   <= ioctl_download;
      push_v <= 1'b0;
      if (start) begin
        pack     <= '0;
        idx      <= '0;
        words    <= '0;
        bad      <= 1'b0;
        tgt_addr <= '0;
      end else begin
        if (pop) tgt_addr <= tgt_addr + AW'(1);
        if (push_v) begin
          if (room) words <= words + (AW+1)'(1);
          else      bad   <= 1'b1;
        end
        if (accept) begin
          if (last) begin
            push_v <= 1'b1;
            push_d <= pack_nxt;
            pack   <= '0;
            idx    <= '0;
          end else begin
            pack <= pack_nxt;
            idx  <= idx + 2'd1;
          end
        end else if (state == FILL && fall && idx != '0) begin
          push_v <= 1'b1;
          push_d <= pack;
          pack   <= '0;
          idx    <= '0;
          bad    <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_bios_loader.sv
// Self-checking bench for bios_loader: byte stream into 16-bit
// words, small (4-word) and large (64-word) image instances.
module tb_bios_loader;

  localparam int AW = 13;

  typedef struct {
    logic [AW-1:0] a;
    logic [15:0]   d;
  } xfer_t;

  logic        clk_sys = 1'b0;
  logic        reset_n = 1'b0;
  logic        ioctl_download = 1'b0;
  logic [15:0] ioctl_index = '0;
  logic        ioctl_wr = 1'b0;
  logic [7:0]  ioctl_dout = '0;
  logic        tgt_req = 1'b0;

  logic          ioctl_wait, wait2;
  logic          tgt_wr, tgt_wr2;
  logic [AW-1:0] tgt_addr, tgt_addr2;
  logic [15:0]   tgt_din, tgt_din2;
  logic          loaded, loaded2;
  logic          error, error2;

  int checks = 0;
  int errors = 0;
  int req_mode = 1;
  int nstrobe = 0;
  xfer_t cap[$];
  xfer_t cap2[$];

  always #5 clk_sys = ~clk_sys;

  bios_loader #(
    .IN_W(8), .OUT_W(16), .AW(AW),
    .IMG_WORDS(4), .DEPTH(16), .INDEX(0)
  ) dut (
    .clk_sys(clk_sys), .reset_n(reset_n),
    .ioctl_download(ioctl_download),
    .ioctl_index(ioctl_index),
    .ioctl_wr(ioctl_wr), .ioctl_dout(ioctl_dout),
    .ioctl_wait(ioctl_wait), .tgt_req(tgt_req),
    .tgt_wr(tgt_wr), .tgt_addr(tgt_addr),
    .tgt_din(tgt_din), .loaded(loaded), .error(error)
  );

  bios_loader #(
    .IN_W(8), .OUT_W(16), .AW(AW),
    .IMG_WORDS(64), .DEPTH(16), .INDEX(0)
  ) dut_big (
    .clk_sys(clk_sys), .reset_n(reset_n),
    .ioctl_download(ioctl_download),
    .ioctl_index(ioctl_index),
    .ioctl_wr(ioctl_wr), .ioctl_dout(ioctl_dout),
    .ioctl_wait(wait2), .tgt_req(tgt_req),
    .tgt_wr(tgt_wr2), .tgt_addr(tgt_addr2),
    .tgt_din(tgt_din2), .loaded(loaded2), .error(error2)
  );

  always @(posedge clk_sys) begin
    #1;
    case (req_mode)
      0:       tgt_req = 1'($urandom_range(0, 1));
      1:       tgt_req = 1'b1;
      default: tgt_req = 1'b0;
    endcase
  end

  always @(negedge clk_sys) begin
    if (ioctl_wr) nstrobe++;
    if (reset_n && tgt_wr && tgt_req)
      cap.push_back('{tgt_addr, tgt_din});
    if (reset_n && tgt_wr2 && tgt_req)
      cap2.push_back('{tgt_addr2, tgt_din2});
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk_sys);
    #1;
  endtask

  // Reference: pairs of bytes little-endian, odd tail zero-padded,
  // capped at the image length; OK only for an exact-length stream.
  function automatic void model(input logic [7:0] b[$],
                                input int img,
                                output logic [15:0] w[$],
                                output bit ok);
    int nw;
    logic [7:0] hi;
    w = {};
    nw = (b.size() + 1) / 2;
    for (int i = 0; i < nw && i < img; i++) begin
      hi = (2*i + 1 < b.size()) ? b[2*i+1] : 8'h00;
      w.push_back({hi, b[2*i]});
    end
    ok = (b.size() == 2 * img);
  endfunction

  task automatic strobe(input logic [7:0] v);
    int t;
    t = 0;
    while ((ioctl_wait || wait2) && t < 500) begin
      cyc(1);
      t++;
    end
    if (t >= 500) chk("wait_bound", 32'(t), 0);
    ioctl_dout = v;
    ioctl_wr = 1'b1;
    cyc(1);
    ioctl_wr = 1'b0;
  endtask

  task automatic send(input logic [7:0] b[$],
                      input logic [15:0] idx,
                      input bit gaps);
    ioctl_index = idx;
    ioctl_download = 1'b1;
    cyc(2);
    for (int i = 0; i < b.size(); i++) begin
      strobe(b[i]);
      if (gaps) cyc($urandom_range(0, 2));
    end
    cyc(1);
    ioctl_download = 1'b0;
    cyc(1);
  endtask

  task automatic verify(input string tag,
                        input logic [7:0] b[$],
                        input bit big,
                        input int base);
    logic [15:0] w[$];
    bit ok;
    int t;
    xfer_t c;
    int n;
    model(b, big ? 64 : 4, w, ok);
    t = 0;
    while (!(big ? (loaded2 | error2) : (loaded | error))
           && t < 400) begin
      cyc(1);
      t++;
    end
    chk({tag, "_done_bound"}, 32'(t < 400), 1);
    cyc(3);
    n = big ? cap2.size() - base : cap.size() - base;
    chk({tag, "_loaded"}, big ? loaded2 : loaded, 32'(ok));
    chk({tag, "_error"}, big ? error2 : error, 32'(!ok));
    chk({tag, "_nwords"}, 32'(n), 32'(w.size()));
    for (int i = 0; i < n && i < w.size(); i++) begin
      c = big ? cap2[base+i] : cap[base+i];
      chk({tag, "_addr"}, 32'(c.a), 32'(i));
      chk({tag, "_data"}, 32'(c.d), 32'(w[i]));
    end
  endtask

  initial begin
    logic [7:0] b[$];
    int base, base2, t, s0;

    cyc(3);
    chk("rst_tgt_wr", tgt_wr, 0);
    chk("rst_tgt_din", tgt_din, 0);
    chk("rst_tgt_addr", 32'(tgt_addr), 0);
    chk("rst_wait", ioctl_wait, 0);
    chk("rst_loaded", loaded, 0);
    chk("rst_error", error, 0);
    reset_n = 1'b1;
    cyc(2);

    // wrong index: nothing happens
    b = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    base = cap.size();
    base2 = cap2.size();
    send(b, 16'h0003, 0);
    cyc(10);
    chk("idx_nowr", 32'(cap.size() - base), 0);
    chk("idx_nowr2", 32'(cap2.size() - base2), 0);
    chk("idx_loaded", loaded, 0);
    chk("idx_error", error, 0);

    base = cap.size();
    send(b, 16'h0000, 0);
    verify("exact", b, 0, base);

    b = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77};
    base = cap.size();
    send(b, 16'h0000, 0);
    verify("short", b, 0, base);

    b = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05,
          8'h06, 8'h07, 8'h08, 8'h09, 8'h0a};
    base = cap.size();
    send(b, 16'h0000, 0);
    verify("long", b, 0, base);

    // stall the target while 40 bytes arrive at the 64-word instance
    b = {};
    for (int i = 0; i < 40; i++) b.push_back(8'($urandom));
    base2 = cap2.size();
    s0 = nstrobe;
    req_mode = 2;
    fork
      send(b, 16'h0000, 0);
      begin
        cyc(40);
        req_mode = 1;
      end
      begin
        t = 0;
        while (!wait2 && t < 60) begin
          @(negedge clk_sys);
          t++;
        end
        chk("stall_wait_seen", wait2, 1);
        chk("stall_wait_at", 32'(nstrobe - s0 >= 28 &&
                                 nstrobe - s0 <= 30), 1);
        chk("stall_no_xfer", 32'(cap2.size() - base2), 0);
      end
    join
    verify("stall", b, 1, base2);

    // random lengths, data, gaps and target back-pressure
    req_mode = 0;
    for (int k = 0; k < 6; k++) begin
      b = {};
      t = $urandom_range(1, 12);
      for (int i = 0; i < t; i++) b.push_back(8'($urandom));
      base = cap.size();
      send(b, 16'h0000, 1'($urandom_range(0, 1)));
      verify("rand", b, 0, base);
    end

    // reset in the middle of a download
    req_mode = 1;
    b = '{8'ha1, 8'ha2, 8'ha3, 8'ha4, 8'ha5, 8'ha6};
    base = cap.size();
    ioctl_index = 16'h0000;
    ioctl_download = 1'b1;
    cyc(2);
    for (int i = 0; i < 6; i++) strobe(b[i]);
    t = 0;
    while (cap.size() - base < 3 && t < 50) begin
      cyc(1);
      t++;
    end
    chk("mid_three_words", 32'(cap.size() - base), 3);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_tgt_wr", tgt_wr, 0);
    chk("mid_rst_wait", ioctl_wait, 0);
    chk("mid_rst_addr", 32'(tgt_addr), 0);
    cyc(1);
    reset_n = 1'b1;
    base = cap.size();
    strobe(8'hb1);
    strobe(8'hb2);
    strobe(8'hb3);
    cyc(3);
    ioctl_download = 1'b0;
    cyc(5);
    chk("mid_ignored", 32'(cap.size() - base), 0);
    chk("mid_loaded", loaded, 0);
    b = '{8'hc1, 8'hc2, 8'hc3, 8'hc4, 8'hc5, 8'hc6, 8'hc7, 8'hc8};
    base = cap.size();
    send(b, 16'h0000, 0);
    verify("reload", b, 0, base);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
